apb_cmd_master: RTL and testbench

- APB4 requester (master) for the serial-link bridge; the opposite end of the bridge's APB completer register block.
- Takes single-beat read/write commands on a valid/ready command port and drives one APB transfer per command: SETUP, then ACCESS.
- Returns read data and error status on a valid/ready response port.
- A watchdog terminates transfers to a hung completer.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_watchdog.sv | 39 +++
 rtl/apb_cmd_master.sv | 162 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and bridge register map for the APB command master and its models.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;

  localparam int unsigned CMD_ADDR_WIDTH = 10;

  typedef struct packed {
    logic                      write;
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [31:0]               wdata;
    logic [3:0]                strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } apb_rsp_t;

  localparam logic [CMD_ADDR_WIDTH-1:0] DATA_REG_ADDR   = 10'd5;
  localparam logic [CMD_ADDR_WIDTH-1:0] CONFIG_REG_ADDR = 10'd6;
  localparam logic [CMD_ADDR_WIDTH-1:0] STATUS_REG_ADDR = 10'd7;

endpackage

// File: rtl/apb_watchdog.sv
// Saturating stall counter; flags the stall cycle that reaches TIMEOUT_CYCLES (0 = never).
module apb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  localparam logic [CntW-1:0] LastCount =
    CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the stall edge that would bring the count to TIMEOUT_CYCLES.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt_q == LastCount);

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: one SETUP/ACCESS transfer per command, response held until consumed.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [31:0]           prdata,
  input  logic                  pslverr
);

  apb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  apb_rsp_t              rsp_q, rsp_d;

  logic cmd_fire, in_access, access_done, wd_enable, wd_expired;

  assign cmd_ready   = (state_q == IDLE);
  assign cmd_fire    = cmd_ready && cmd_valid;
  assign in_access   = (state_q == ACCESS) && psel_q && penable_q;
  assign access_done = in_access && pready;
  assign wd_enable   = in_access && !pready;

  apb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_watchdog (
    .pclk    (pclk),
    .preset_n(preset_n),
    .clear   (cmd_fire),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (access_done || wd_expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_write ? cmd_wdata : 32'h0;
          pstrb_d   = cmd_write ? cmd_strb : 4'h0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        // A completion on the abort edge takes priority over the watchdog.
        if (access_done) begin
          rsp_d.rdata   = pwrite_q ? 32'h0 : prdata;
          rsp_d.err     = pslverr;
          rsp_d.timeout = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
        end else if (wd_expired) begin
          rsp_d.rdata   = 32'h0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
        end
      end
      RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench: main DUT with an 8-cycle watchdog, shadow DUT with the watchdog disabled.
module tb_apb_cmd_master;
  import apb_pkg::*;

  logic        pclk, preset_n;
  logic        cmd_valid, cmd_write, rsp_ready, pready, pslverr;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata, prdata;
  logic [3:0]  cmd_strb;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite;
  logic [31:0] rsp_rdata, pwdata;
  logic [9:0]  paddr;
  logic [3:0]  pstrb;

  logic        cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0, psel0, penable0, pwrite0;
  logic [31:0] rsp_rdata0, pwdata0;
  logic [9:0]  paddr0;
  logic [3:0]  pstrb0;

  int n_assert = 0;
  int n_fail   = 0;

  apb_cmd_master #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(8)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  apb_cmd_master #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0),
    .paddr(paddr0), .psel(psel0), .penable(penable0), .pwrite(pwrite0),
    .pwdata(pwdata0), .pstrb(pstrb0), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_cmd(input logic wr, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  initial begin
    preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #1;
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset psel", psel, 0);
    chk("reset penable", penable, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset paddr", paddr, 0);
    chk("reset pwdata", pwdata, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset cmd_ready0", cmd_ready0, 1);
    tick(); tick();
    preset_n = 1'b1;

    // Write, zero wait
    pready = 1'b1;
    put_cmd(1'b1, DATA_REG_ADDR, 32'hA5A5_1234, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("wr setup psel", psel, 1);
    chk("wr setup penable", penable, 0);
    chk("wr setup paddr", paddr, 5);
    chk("wr setup pwrite", pwrite, 1);
    chk("wr setup pwdata", pwdata, 32'hA5A5_1234);
    chk("wr setup pstrb", pstrb, 4'hF);
    chk("wr setup cmd_ready", cmd_ready, 0);
    tick();
    chk("wr access penable", penable, 1);
    chk("wr access paddr", paddr, 5);
    chk("wr access rsp_valid", rsp_valid, 0);
    tick();
    chk("wr rsp_valid", rsp_valid, 1);
    chk("wr rsp_err", rsp_err, 0);
    chk("wr rsp_rdata", rsp_rdata, 0);
    chk("wr psel dropped", psel, 0);
    chk("wr rsp_valid0", rsp_valid0, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr rsp consumed", rsp_valid, 0);
    chk("wr cmd_ready back", cmd_ready, 1);

    // Read, two wait states
    pready = 1'b0;
    prdata = 32'h0000_003C;
    put_cmd(1'b0, CONFIG_REG_ADDR, 32'hFFFF_FFFF, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("rd setup pwrite", pwrite, 0);
    chk("rd setup pwdata", pwdata, 0);
    chk("rd setup pstrb", pstrb, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rd penable held", penable, 1);
      chk("rd no early rsp", rsp_valid, 0);
    end
    pready = 1'b1;
    tick();
    chk("rd penable dropped", penable, 0);
    chk("rd rsp_valid", rsp_valid, 1);
    chk("rd rsp_rdata", rsp_rdata, 32'h3C);
    chk("rd rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Slave error, then a normal command
    pslverr = 1'b1;
    put_cmd(1'b1, 10'd9, 32'h1, 4'h1);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    pslverr = 1'b0;
    chk("slverr rsp_valid", rsp_valid, 1);
    chk("slverr rsp_err", rsp_err, 1);
    chk("slverr rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    put_cmd(1'b1, STATUS_REG_ADDR, 32'h2, 4'h3);
    tick();
    cmd_valid = 1'b0;
    chk("after err psel", psel, 1);
    chk("after err paddr", paddr, 7);
    tick(); tick();
    chk("after err rsp_valid", rsp_valid, 1);
    chk("after err rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Response back-pressure with cmd_valid held
    prdata = 32'h0000_5A5A;
    put_cmd(1'b0, DATA_REG_ADDR, 32'h0, 4'h0);
    tick(); tick(); tick();
    chk("bp rsp_valid", rsp_valid, 1);
    prdata = 32'h0000_1111;
    put_cmd(1'b0, CONFIG_REG_ADDR, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp rsp_valid held", rsp_valid, 1);
      chk("bp rsp_rdata held", rsp_rdata, 32'h5A5A);
      chk("bp cmd_ready low", cmd_ready, 0);
      chk("bp no psel", psel, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp rsp handshake", rsp_valid, 0);
    chk("bp cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("bp second psel", psel, 1);
    chk("bp second paddr", paddr, 6);
    tick(); tick();
    chk("bp second rdata", rsp_rdata, 32'h1111);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Watchdog: pready stuck low
    pready = 1'b0;
    prdata = 32'h0000_BEEF;
    put_cmd(1'b0, STATUS_REG_ADDR, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("wd psel held", psel, 1);
    end
    tick();
    chk("wd psel dropped", psel, 0);
    chk("wd penable dropped", penable, 0);
    chk("wd rsp_valid", rsp_valid, 1);
    chk("wd rsp_err", rsp_err, 1);
    chk("wd rsp_timeout", rsp_timeout, 1);
    chk("wd rsp_rdata", rsp_rdata, 0);
    chk("wd0 psel held", psel0, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wd rsp consumed", rsp_valid, 0);
    repeat (20) tick();
    chk("wd0 psel still", psel0, 1);
    chk("wd0 penable still", penable0, 1);
    chk("wd0 no rsp", rsp_valid0, 0);

    // Completion on the abort edge wins
    put_cmd(1'b0, DATA_REG_ADDR, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    chk("race psel held", psel, 1);
    pready = 1'b1;
    prdata = 32'h0000_0077;
    tick();
    chk("race rsp_valid", rsp_valid, 1);
    chk("race rsp_timeout", rsp_timeout, 0);
    chk("race rsp_err", rsp_err, 0);
    chk("race rsp_rdata", rsp_rdata, 32'h77);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset mid-ACCESS
    pready = 1'b0;
    put_cmd(1'b1, DATA_REG_ADDR, 32'hCAFE, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst pre penable", penable, 1);
    #2;
    preset_n = 1'b0;
    pready   = 1'b1;
    #1;
    chk("rst async psel", psel, 0);
    chk("rst async penable", penable, 0);
    chk("rst async rsp_valid", rsp_valid, 0);
    chk("rst async psel0", psel0, 0);
    tick(); tick();
    preset_n = 1'b1;
    chk("rst cmd_ready", cmd_ready, 1);
    tick(); tick();
    chk("rst no stale rsp", rsp_valid, 0);
    chk("rst no psel", psel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
